// File: rtl/clk_switch_ctrl_if.sv
// Request/status bundle between the system control registers and the clock-switch controller.
interface clk_switch_ctrl_if;
  logic req_valid_i;
  logic req_sel_i;
  logic req_ready_o;
  logic active_sel_o;
  logic busy_o;
  logic done_o;
  logic err_o;
  logic lost_lock_o;

  modport slave (
    input  req_valid_i, req_sel_i,
    output req_ready_o, active_sel_o, busy_o, done_o, err_o, lost_lock_o
  );

  modport master (
    output req_valid_i, req_sel_i,
    input  req_ready_o, active_sel_o, busy_o, done_o, err_o, lost_lock_o
  );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Sequences PLL1/PLL2 source changes on the glitch-free clock mux: wait for stable
// target lock, drive select, hold until the handover settles, watch the active lock.
module clk_switch_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_STABLE   = 8,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic           clk_i,
  input  logic           arst_i,
  input  logic           pll_1_locked_i,
  input  logic           pll_2_locked_i,
  output logic           sel_o,
  clk_switch_ctrl_if.slave bus
);
  localparam int ST_W  = $clog2(LOCK_STABLE + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(LOCK_STABLE);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(LOCK_TIMEOUT);
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT_LOCK, SWITCH, SETTLE} state_t;

  state_t           state_q, state_d;
  logic [SYNC_STAGES-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prime_q, prime_d;
  logic             sel_q, sel_d, act_q, act_d, tgt_q, tgt_d;
  logic             done_q, done_d, err_q, err_d, lost_q, lost_d;
  logic [ST_W-1:0]  stable_q, stable_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             lk1, lk2, lk_tgt, lk_act, armed;

  assign lk1    = sync1_q[SYNC_STAGES-1];
  assign lk2    = sync2_q[SYNC_STAGES-1];
  assign lk_tgt = tgt_q ? lk2 : lk1;
  assign lk_act = act_q ? lk2 : lk1;
  // Synchronizers come out of reset reading 0; the lost-lock monitor stays
  // disarmed until the pipeline has filled with real samples.
  assign armed  = prime_q[SYNC_STAGES-1];

  always_comb begin
    sync1_d  = {sync1_q[SYNC_STAGES-2:0], pll_1_locked_i};
    sync2_d  = {sync2_q[SYNC_STAGES-2:0], pll_2_locked_i};
    prime_d  = {prime_q[SYNC_STAGES-2:0], 1'b1};
    state_d  = state_q;
    sel_d    = sel_q;
    act_d    = act_q;
    tgt_d    = tgt_q;
    stable_d = stable_q;
    tmo_d    = tmo_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    lost_d   = lost_q;
    unique case (state_q)
      IDLE: begin
        if (armed && !lk_act) lost_d = 1'b1;
        if (bus.req_valid_i) begin
          lost_d = 1'b0;
          tgt_d  = bus.req_sel_i;
          if (bus.req_sel_i == act_q) begin
            done_d = 1'b1;
          end else begin
            state_d  = WAIT_LOCK;
            stable_d = '0;
            tmo_d    = '0;
          end
        end
      end
      WAIT_LOCK: begin
        tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        if (lk_tgt) stable_d = (stable_q == ST_MAX) ? stable_q : stable_q + 1'b1;
        else        stable_d = '0;
        // Switch takes priority when lock qualifies on the timeout cycle.
        if (stable_d == ST_MAX) begin
          state_d = SWITCH;
        end else if (tmo_d == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      SWITCH: begin
        sel_d    = tgt_q;
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        settle_d = (settle_q == SET_MAX) ? settle_q : settle_q + 1'b1;
        if (settle_d == SET_MAX) begin
          act_d   = tgt_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prime_q  <= '0;
      sel_q    <= 1'b0;
      act_q    <= 1'b0;
      tgt_q    <= 1'b0;
      stable_q <= '0;
      tmo_q    <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prime_q  <= prime_d;
      sel_q    <= sel_d;
      act_q    <= act_d;
      tgt_q    <= tgt_d;
      stable_q <= stable_d;
      tmo_q    <= tmo_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
    end
  end

  assign sel_o            = sel_q;
  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.active_sel_o = act_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.lost_lock_o  = lost_q;
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: reset, no-op request, timeout, switch latency,
// lost-lock monitor, lock glitch restart and reset during settle.
module tb_clk_switch_ctrl;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic pll1 = 1'b1;
  logic pll2 = 1'b0;
  logic sel;
  int   total = 0;
  int   bad   = 0;

  clk_switch_ctrl_if bus();

  clk_switch_ctrl dut (
    .clk_i          (clk),
    .arst_i         (arst),
    .pll_1_locked_i (pll1),
    .pll_2_locked_i (pll2),
    .sel_o          (sel),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1ns past the last one.
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a request for one edge; returns positioned in cycle T+1.
  task automatic accept(input logic s);
    bus.req_valid_i = 1'b1;
    bus.req_sel_i   = s;
    step(1);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    bus.req_valid_i = 1'b0;
    bus.req_sel_i   = 1'b0;
    arst = 1'b1; pll1 = 1'b1; pll2 = 1'b0;
    step(3);
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL rst_sel_held got=%b exp=0", sel); end
    arst = 1'b0;
    step(1);
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL rst_sel got=%b exp=0", sel); end
    total++; if (bus.active_sel_o !== 1'b0) begin bad++; $display("FAIL rst_active got=%b exp=0", bus.active_sel_o); end
    total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
    total++; if ({bus.done_o, bus.err_o} !== 2'b00) begin bad++; $display("FAIL rst_pulses got=%b exp=00", {bus.done_o, bus.err_o}); end
    step(4);
    total++; if (bus.lost_lock_o !== 1'b0) begin bad++; $display("FAIL rst_lost got=%b exp=0", bus.lost_lock_o); end
  endtask

  task automatic test_no_switch;
    accept(1'b0);
    total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL noswitch_done got=%b exp=1", bus.done_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL noswitch_busy got=%b exp=0", bus.busy_o); end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL noswitch_sel got=%b exp=0", sel); end
    step(1);
    total++; if ({bus.done_o, bus.busy_o} !== 2'b00) begin bad++; $display("FAIL noswitch_after got=%b exp=00", {bus.done_o, bus.busy_o}); end
  endtask

  task automatic test_timeout;
    pll2 = 1'b0;
    step(2);
    accept(1'b1);
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL tmo_busy got=%b exp=1", bus.busy_o); end
    step(1023);
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", bus.err_o); end
    step(1);
    total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", bus.err_o); end
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL tmo_done got=%b exp=0", bus.done_o); end
    total++; if ({sel, bus.active_sel_o} !== 2'b00) begin bad++; $display("FAIL tmo_sel got=%b exp=00", {sel, bus.active_sel_o}); end
    total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL tmo_ready got=%b exp=1", bus.req_ready_o); end
    step(1);
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL tmo_pulse got=%b exp=0", bus.err_o); end
  endtask

  task automatic test_switch;
    pll2 = 1'b1;
    step(10);
    accept(1'b1);
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL sw_busy_first got=%b exp=1", bus.busy_o); end
    step(8);
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL sw_sel_early got=%b exp=0", sel); end
    step(1);
    total++; if (sel !== 1'b1) begin bad++; $display("FAIL sw_sel got=%b exp=1", sel); end
    total++; if (bus.active_sel_o !== 1'b0) begin bad++; $display("FAIL sw_active_early got=%b exp=0", bus.active_sel_o); end
    step(15);
    total++; if ({bus.busy_o, bus.done_o} !== 2'b10) begin bad++; $display("FAIL sw_last_busy got=%b exp=10", {bus.busy_o, bus.done_o}); end
    step(1);
    total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL sw_done got=%b exp=1", bus.done_o); end
    total++; if (bus.active_sel_o !== 1'b1) begin bad++; $display("FAIL sw_active got=%b exp=1", bus.active_sel_o); end
    total++; if ({bus.req_ready_o, bus.busy_o} !== 2'b10) begin bad++; $display("FAIL sw_idle got=%b exp=10", {bus.req_ready_o, bus.busy_o}); end
    step(1);
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL sw_done_pulse got=%b exp=0", bus.done_o); end
  endtask

  task automatic test_lost_lock;
    pll2 = 1'b0;
    step(2);
    total++; if (bus.lost_lock_o !== 1'b0) begin bad++; $display("FAIL lost_early got=%b exp=0", bus.lost_lock_o); end
    step(1);
    total++; if (bus.lost_lock_o !== 1'b1) begin bad++; $display("FAIL lost_set got=%b exp=1", bus.lost_lock_o); end
    pll2 = 1'b1;
    step(4);
    total++; if (bus.lost_lock_o !== 1'b1) begin bad++; $display("FAIL lost_sticky got=%b exp=1", bus.lost_lock_o); end
    accept(1'b1);
    total++; if (bus.lost_lock_o !== 1'b0) begin bad++; $display("FAIL lost_clear got=%b exp=0", bus.lost_lock_o); end
    total++; if ({bus.done_o, sel} !== 2'b11) begin bad++; $display("FAIL lost_req got=%b exp=11", {bus.done_o, sel}); end
  endtask

  task automatic test_lock_glitch;
    // Switch back to PLL1 with a one-cycle lock dropout after four stable cycles.
    accept(1'b0);
    step(2);
    pll1 = 1'b0;
    step(1);
    pll1 = 1'b1;
    step(10);
    total++; if (sel !== 1'b1) begin bad++; $display("FAIL glitch_sel_early got=%b exp=1", sel); end
    step(1);
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL glitch_sel got=%b exp=0", sel); end
    step(15);
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL glitch_done_early got=%b exp=0", bus.done_o); end
    step(1);
    total++; if ({bus.done_o, bus.active_sel_o} !== 2'b10) begin bad++; $display("FAIL glitch_done got=%b exp=10", {bus.done_o, bus.active_sel_o}); end
  endtask

  task automatic test_reset_in_settle;
    pll2 = 1'b1;
    step(2);
    accept(1'b1);
    step(14);
    total++; if ({sel, bus.busy_o} !== 2'b11) begin bad++; $display("FAIL rs_pre got=%b exp=11", {sel, bus.busy_o}); end
    arst = 1'b1;
    #1;
    total++; if ({sel, bus.active_sel_o} !== 2'b00) begin bad++; $display("FAIL rs_async got=%b exp=00", {sel, bus.active_sel_o}); end
    step(2);
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL rs_done_held got=%b exp=0", bus.done_o); end
    arst = 1'b0;
    step(1);
    total++; if ({bus.req_ready_o, bus.busy_o, bus.done_o, sel} !== 4'b1000) begin bad++; $display("FAIL rs_idle got=%b exp=1000", {bus.req_ready_o, bus.busy_o, bus.done_o, sel}); end
    step(20);
    total++; if ({bus.done_o, bus.lost_lock_o, sel} !== 3'b000) begin bad++; $display("FAIL rs_quiet got=%b exp=000", {bus.done_o, bus.lost_lock_o, sel}); end
  endtask

  initial begin
    test_reset();
    test_no_switch();
    test_timeout();
    test_switch();
    test_lost_lock();
    test_lock_glitch();
    test_reset_in_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
Reference-clock-domain controller that sequences source changes on the glitch-free 2:1 PLL clock mux. It accepts a switch request through a valid/ready handshake and waits for the target PLL to show stable lock. It then drives the mux select and holds off completion until the mux handover has settled. It also reports timeouts and loss of lock on the active source. It sits in the CRG between the PLLs/mux and the system control registers.

Parameters:
SYNC_STAGES, 2, flops in each lock-input synchronizer (>=2)
LOCK_STABLE, 8, consecutive synchronized-lock cycles required before switching (>=1)
LOCK_TIMEOUT, 1024, max cycles in WAIT_LOCK before error (> LOCK_STABLE)
SETTLE_CYCLES, 16, cycles held after select change before completion (>=1)

Ports:
clk_i  input  1  free-running reference clock; all logic on posedge
arst_i  input  1  asynchronous active-high reset
req_valid_i  input  1  switch request valid; held until accepted
req_sel_i  input  1  requested source: 0 = PLL1, 1 = PLL2
req_ready_o  output  1  high when controller can accept a request (state IDLE)
pll_1_locked_i  input  1  PLL1 lock, asynchronous to clk_i
pll_2_locked_i  input  1  PLL2 lock, asynchronous to clk_i
sel_o  output  1  select to clock mux
active_sel_o  output  1  committed source after settle completes
busy_o  output  1  high in any state other than IDLE
done_o  output  1  one-cycle pulse: request completed
err_o  output  1  one-cycle pulse: lock timeout, request aborted
lost_lock_o  output  1  sticky: active source lost lock while IDLE

Behaviour:
- Reset (async assert, sync-released state): state IDLE, sel_o=0, active_sel_o=0, done_o=0, err_o=0, lost_lock_o=0, all counters 0, synchronizer flops 0. req_ready_o=1 and busy_o=0 follow from IDLE.
- Reset mid-operation forces sel_o=0 immediately. The mux is relied on for a glitch-free return to PLL1.
- Lock inputs pass through SYNC_STAGES flops. All decisions use the synchronized values (lk1, lk2).
- req_ready_o = (state==IDLE), combinational from the state register. Acceptance happens when req_valid_i && req_ready_o at a posedge (cycle T). The target is latched then.
- Accepting a request clears lost_lock_o.
- IDLE, target==active_sel_o: no switch. State stays IDLE and done_o pulses in cycle T+1.
- IDLE, target!=active_sel_o: go to WAIT_LOCK with stable_cnt=0 and tmo_cnt=0.
- WAIT_LOCK: tmo_cnt increments every cycle. stable_cnt increments while the target's lock is high and clears to 0 whenever it is low.
  - When stable_cnt reaches LOCK_STABLE, go to SWITCH.
  - Otherwise, when tmo_cnt reaches LOCK_TIMEOUT, pulse err_o, return to IDLE, and leave sel_o/active_sel_o unchanged.
  - If both conditions hit in the same cycle, the switch wins.
- SWITCH (1 cycle): sel_o <= target; go to SETTLE with settle_cnt=0.
- SETTLE: settle_cnt increments. When it reaches SETTLE_CYCLES: active_sel_o <= target, done_o pulses, state returns to IDLE.
  - Lock loss of the target during SETTLE does not abort the switch. Once IDLE is reached, the lost-lock monitor flags it.
- Latency with target lock already synchronized high: done_o is high in cycle T+LOCK_STABLE+SETTLE_CYCLES+2. sel_o changes in cycle T+LOCK_STABLE+2.
- Timeout latency with lock low throughout: err_o is high in cycle T+LOCK_TIMEOUT+1.
- Lost-lock monitor: in IDLE, if the active source's lock is low, lost_lock_o sets and stays set until reset or the next accepted request. There is no automatic failover.
- req_valid_i while busy is ignored; no queueing. done_o and err_o are never high in the same cycle.
- Counter widths are $clog2(max value + 1), and counters saturate rather than wrap.

Test Plan:
- Reset with pll_1 locked, then hold arst_i=0 -> sel_o=0, active_sel_o=0, req_ready_o=1, no pulses, lost_lock_o=0.
- pll_2_locked_i high 10 cycles beforehand; request sel=1 accepted at T -> sel_o rises at T+10, busy_o high T+1..T+25, done_o and active_sel_o=1 at T+26, req_ready_o=1 at T+26.
- Request sel=0 while active_sel_o=0 -> done_o pulse at T+1, sel_o unchanged, busy_o never high.
- pll_2_locked_i low throughout; request sel=1 -> err_o at T+1025, sel_o stays 0, active_sel_o stays 0, back in IDLE.
- pll_2 lock toggles low at the 5th stable cycle, then stays high -> stable_cnt restarts; switch occurs only after 8 further consecutive high cycles; done_o as per latency plus the delay.
- Active source lock drops in IDLE -> lost_lock_o sets (after sync delay) and stays set; next accepted request clears it.
- Assert arst_i during SETTLE after a switch to PLL2 -> sel_o=0 and active_sel_o=0 asynchronously; no done_o; IDLE after release.
